// File: rtl/rob_commit.sv
// In-order retire stage behind the reorder buffer: retires the longest eligible prefix of the
// oldest EXT_COUNT slots, drives RF writes and a held store request. Optional: COMMIT_PERF_EN.
module rob_commit #(
  parameter int EXT_COUNT    = 4,
  parameter int RF_WR_COUNT  = 2,
  parameter int EXTCOUNTLOG2 = $clog2(EXT_COUNT)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [EXT_COUNT-1:0]    slot_valid,
  input  logic [EXT_COUNT-1:0]    slot_kill,
  input  logic [4:0]              slot_dest_reg   [EXT_COUNT],
  input  logic [EXT_COUNT-1:0]    slot_dest_valid,
  input  logic [31:0]             slot_result     [EXT_COUNT],
  input  logic [EXT_COUNT-1:0]    slot_is_store,
  input  logic [31:0]             slot_st_addr    [EXT_COUNT],
  input  logic [31:0]             slot_st_data    [EXT_COUNT],
  input  logic [3:0]              slot_st_be      [EXT_COUNT],
  input  logic [EXT_COUNT-1:0]    slot_halt,
  input  logic                    rob_empty,
  output logic                    consume,
  output logic [EXTCOUNTLOG2-1:0] consume_count,
  output logic [RF_WR_COUNT-1:0]  rf_we,
  output logic [4:0]              rf_waddr [RF_WR_COUNT],
  output logic [31:0]             rf_wdata [RF_WR_COUNT],
  output logic                    st_valid,
  input  logic                    st_ready,
  output logic [31:0]             st_addr,
  output logic [31:0]             st_data,
  output logic [3:0]              st_be,
  output logic                    halted,
  output logic [31:0]             retired_cnt,
  output logic [31:0]             killed_cnt
);

  typedef enum logic {RUN, HALTED} state_e;

  state_e state_q, state_d;
  logic [RF_WR_COUNT-1:0] rf_we_q, rf_we_d;
  logic [4:0]  rf_waddr_q [RF_WR_COUNT];
  logic [4:0]  rf_waddr_d [RF_WR_COUNT];
  logic [31:0] rf_wdata_q [RF_WR_COUNT];
  logic [31:0] rf_wdata_d [RF_WR_COUNT];
  logic        st_valid_q, st_valid_d;
  logic [31:0] st_addr_q, st_addr_d, st_data_q, st_data_d;
  logic [3:0]  st_be_q, st_be_d;
  logic        open, ok, st_seen, st_free, halt_hit;
  int          n, wr_cnt;
`ifdef COMMIT_PERF_EN
  logic [31:0] retired_cnt_q, retired_cnt_d, killed_cnt_q, killed_cnt_d;
  int          ret_n, kill_n;
`endif

  // Valid/ready: a store request transfers on a cycle where st_valid && st_ready; the payload
  // is held stable while st_valid is high and not yet accepted.
  always_comb begin
    open       = 1'b1;
    ok         = 1'b0;
    n          = 0;
    wr_cnt     = 0;
    st_seen    = 1'b0;
    halt_hit   = 1'b0;
    st_free    = !st_valid_q || st_ready;
    rf_we_d    = '0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    st_valid_d = st_valid_q && !st_ready;
    st_addr_d  = st_addr_q;
    st_data_d  = st_data_q;
    st_be_d    = st_be_q;
`ifdef COMMIT_PERF_EN
    ret_n  = 0;
    kill_n = 0;
`endif
    for (int i = 0; i < EXT_COUNT; i++) begin
      ok = open && slot_valid[i] && !rob_empty && (state_q == RUN);
      // A halt carries no register or store side effect of its own.
      if (ok && !slot_kill[i] && !slot_halt[i]) begin
        if (slot_is_store[i] && (st_seen || !st_free)) ok = 1'b0;
        if (slot_dest_valid[i] && (wr_cnt >= RF_WR_COUNT)) ok = 1'b0;
      end
      if (!ok) begin
        open = 1'b0;
      end else begin
        n = n + 1;
        if (slot_kill[i]) begin
`ifdef COMMIT_PERF_EN
          kill_n = kill_n + 1;
`endif
        end else begin
`ifdef COMMIT_PERF_EN
          ret_n = ret_n + 1;
`endif
          if (slot_halt[i]) begin
            halt_hit = 1'b1;
            open     = 1'b0;
          end else begin
            if (slot_is_store[i]) begin
              st_seen    = 1'b1;
              st_valid_d = 1'b1;
              st_addr_d  = slot_st_addr[i];
              st_data_d  = slot_st_data[i];
              st_be_d    = slot_st_be[i];
            end
            if (slot_dest_valid[i]) begin
              // A younger write to the same register makes the older one dead.
              for (int p = 0; p < RF_WR_COUNT; p++) begin
                if (p < wr_cnt && rf_waddr_d[p] == slot_dest_reg[i]) rf_we_d[p] = 1'b0;
              end
              for (int p = 0; p < RF_WR_COUNT; p++) begin
                if (p == wr_cnt) begin
                  rf_we_d[p]    = (slot_dest_reg[i] != 5'd0);
                  rf_waddr_d[p] = slot_dest_reg[i];
                  rf_wdata_d[p] = slot_result[i];
                end
              end
              wr_cnt = wr_cnt + 1;
            end
          end
        end
      end
    end
    state_d       = halt_hit ? HALTED : state_q;
    consume       = (n > 0);
    consume_count = (n > 0) ? EXTCOUNTLOG2'(n - 1) : '0;
`ifdef COMMIT_PERF_EN
    retired_cnt_d = retired_cnt_q + 32'(ret_n);
    killed_cnt_d  = killed_cnt_q + 32'(kill_n);
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= RUN;
      rf_we_q    <= '0;
      rf_waddr_q <= '{default: '0};
      rf_wdata_q <= '{default: '0};
      st_valid_q <= 1'b0;
      st_addr_q  <= '0;
      st_data_q  <= '0;
      st_be_q    <= '0;
    end else begin
      state_q    <= state_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      st_valid_q <= st_valid_d;
      st_addr_q  <= st_addr_d;
      st_data_q  <= st_data_d;
      st_be_q    <= st_be_d;
    end
  end

`ifdef COMMIT_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      retired_cnt_q <= '0;
      killed_cnt_q  <= '0;
    end else begin
      retired_cnt_q <= retired_cnt_d;
      killed_cnt_q  <= killed_cnt_d;
    end
  end
  assign retired_cnt = retired_cnt_q;
  assign killed_cnt  = killed_cnt_q;
`else
  assign retired_cnt = '0;
  assign killed_cnt  = '0;
`endif

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign st_valid = st_valid_q;
  assign st_addr  = st_addr_q;
  assign st_data  = st_data_q;
  assign st_be    = st_be_q;
  assign halted   = (state_q == HALTED);

endmodule
